layer_out_serializer: RTL and testbench



---
 rtl/layer_out_serializer.sv | 139 +++++++++++++
 tb/tb_layer_out_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// Captures one layer's NUM node outputs a fixed latency after start, then streams them
// out over valid/ready while tracking the running argmax of the transferred values.
module layer_out_serializer #(
    parameter int unsigned NUM     = 16,
    parameter int unsigned IDXW    = 4,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [NUM*16-1:0] n_in_i,
    output logic [15:0]       out_data_o,
    output logic [IDXW-1:0]   out_idx_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              drop_err_o,
    output logic [IDXW-1:0]   max_idx_o,
    output logic [15:0]       max_val_o,
    output logic              max_valid_o
);

    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     buf_q [NUM];
    logic [15:0]     buf_d [NUM];
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            drop_q, drop_d;
    logic [IDXW-1:0] max_idx_q, max_idx_d;
    logic [15:0]     max_val_q, max_val_d;
    logic            max_valid_q, max_valid_d;

    logic [15:0] cur;
    logic        last;
    logic        xfer;

    assign cur  = buf_q[idx_q];
    assign last = (idx_q == IDXW'(NUM - 1));
    assign xfer = valid_q && out_ready_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        drop_d      = drop_q;
        max_idx_d   = max_idx_q;
        max_val_d   = max_val_q;
        max_valid_d = max_valid_q;

        // Any start outside IDLE is discarded, including the final-transfer cycle.
        if (start_i && (state_q != StIdle)) begin
            drop_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StWait;
                    cnt_d       = CntW'(LATENCY - 1);
                    max_valid_d = 1'b0;
                    max_idx_d   = '0;
                    max_val_d   = '0;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    for (int k = 0; k < NUM; k++) begin
                        buf_d[k] = n_in_i[16*k +: 16];
                    end
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StSend: begin
                if (xfer) begin
                    // Strict compare keeps the lower index on ties; idx 0 seeds the max.
                    if ((cur > max_val_q) || (idx_q == '0)) begin
                        max_idx_d = idx_q;
                        max_val_d = cur;
                    end
                    if (last) begin
                        state_d     = StIdle;
                        valid_d     = 1'b0;
                        max_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            idx_q       <= '0;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
            max_idx_q   <= '0;
            max_val_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            drop_q      <= drop_d;
            max_idx_q   <= max_idx_d;
            max_val_q   <= max_val_d;
            max_valid_q <= max_valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = valid_q ? cur : '0;
    assign out_idx_o   = valid_q ? idx_q : '0;
    assign out_last_o  = valid_q && last;
    assign busy_o      = (state_q != StIdle);
    assign drop_err_o  = drop_q;
    assign max_idx_o   = max_idx_q;
    assign max_val_o   = max_val_q;
    assign max_valid_o = max_valid_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: random node values and ready patterns checked against
// an array/argmax reference model.
module tb_layer_out_serializer;

    localparam int unsigned NUM     = 16;
    localparam int unsigned IDXW    = 4;
    localparam int unsigned LATENCY = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NUM*16-1:0] n_in;
    logic [15:0]       out_data;
    logic [IDXW-1:0]   out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              drop_err;
    logic [IDXW-1:0]   max_idx;
    logic [15:0]       max_val;
    logic              max_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] vals [NUM];
    bit          exp_drop = 1'b0;

    always #5 clk = ~clk;

    layer_out_serializer #(
        .NUM    (NUM),
        .IDXW   (IDXW),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .n_in_i     (n_in),
        .out_data_o (out_data),
        .out_idx_o  (out_idx),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_last_o (out_last),
        .busy_o     (busy),
        .drop_err_o (drop_err),
        .max_idx_o  (max_idx),
        .max_val_o  (max_val),
        .max_valid_o(max_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM*16-1:0] garbage();
        logic [NUM*16-1:0] g;
        for (int k = 0; k < NUM; k++) g[16*k +: 16] = 16'($urandom);
        return g;
    endfunction

    // First index holding the largest value.
    function automatic int argmax();
        int best = 0;
        for (int k = 1; k < NUM; k++) if (vals[k] > vals[best]) best = k;
        return best;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_data"}, 32'(out_data), 32'(0));
        chk({tag, "_idx"}, 32'(out_idx), 32'(0));
        chk({tag, "_last"}, 32'(out_last), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_drop"}, 32'(drop_err), 32'(0));
        chk({tag, "_maxidx"}, 32'(max_idx), 32'(0));
        chk({tag, "_maxval"}, 32'(max_val), 32'(0));
        chk({tag, "_maxvalid"}, 32'(max_valid), 32'(0));
    endtask

    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready.
    task automatic run_seq(input int mode, input bit drop_wait, input bit drop_last);
        logic [NUM*16-1:0] packed_vals;
        int e = 0;
        int cyc = 0;
        bit rdy;
        int best;
        for (int k = 0; k < NUM; k++) packed_vals[16*k +: 16] = vals[k];
        n_in  = garbage();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_maxvalid_clr", 32'(max_valid), 32'(0));
        for (int i = 1; i <= LATENCY; i++) begin
            chk("wait_valid", 32'(out_valid), 32'(0));
            chk("wait_busy", 32'(busy), 32'(1));
            if (drop_wait && i == 1) begin
                start    = 1'b1;
                exp_drop = 1'b1;
            end
            n_in = (i == LATENCY) ? packed_vals : garbage();
            tick();
            start = 1'b0;
        end
        while (e < NUM && cyc < 2000) begin
            n_in = garbage();
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (drop_last && rdy && e == NUM - 1) begin
                start    = 1'b1;
                exp_drop = 1'b1;
            end
            chk("send_valid", 32'(out_valid), 32'(1));
            chk("send_data", 32'(out_data), 32'(vals[e]));
            chk("send_idx", 32'(out_idx), 32'(e));
            chk("send_last", 32'(out_last), 32'(e == NUM - 1));
            tick();
            start = 1'b0;
            if (rdy) e++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("seq_len", 32'(e), 32'(NUM));
        best = argmax();
        chk("done_valid", 32'(out_valid), 32'(0));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_maxvalid", 32'(max_valid), 32'(1));
        chk("done_maxidx", 32'(max_idx), 32'(best));
        chk("done_maxval", 32'(max_val), 32'(vals[best]));
        chk("done_drop", 32'(drop_err), 32'(exp_drop));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        n_in      = garbage();
        #12;
        check_idle_zero("reset");
        tick();
        reset = 1'b0;
        tick();
        check_idle_zero("idle");

        // Ramp 100..115, ready held high.
        for (int k = 0; k < NUM; k++) vals[k] = 16'(100 + k);
        run_seq(0, 1'b0, 1'b0);
        tick();

        // Random values under 1,0,0 backpressure.
        for (int k = 0; k < NUM; k++) vals[k] = 16'($urandom);
        run_seq(1, 1'b0, 1'b0);
        tick();

        // Tie case plus drops during WAIT and on the last transfer.
        for (int k = 0; k < NUM; k++) vals[k] = 16'(0);
        vals[1] = 16'd7;
        vals[2] = 16'd300;
        vals[3] = 16'd12;
        vals[4] = 16'd300;
        run_seq(2, 1'b1, 1'b1);

        // Back-to-back start in the first IDLE cycle; all zeros.
        chk("b2b_maxvalid_before", 32'(max_valid), 32'(1));
        for (int k = 0; k < NUM; k++) vals[k] = 16'(0);
        run_seq(0, 1'b0, 1'b0);

        // Small value range to force many ties, random ready.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NUM; k++) vals[k] = 16'($urandom_range(0, 3));
            vals[$urandom_range(0, NUM - 1)] = 16'hffff;
            run_seq(2, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-SEND at idx 5.
        for (int k = 0; k < NUM; k++) vals[k] = 16'($urandom_range(1, 16'hffff));
        n_in  = garbage();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= LATENCY; i++) begin
            if (i == LATENCY) for (int k = 0; k < NUM; k++) n_in[16*k +: 16] = vals[k];
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        chk("pre_reset_idx", 32'(out_idx), 32'(5));
        chk("pre_reset_data", 32'(out_data), 32'(vals[5]));
        #2;
        reset = 1'b1;
        #1;
        exp_drop = 1'b0;
        check_idle_zero("async_reset");
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_idle_zero("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
